pipe_mips32: RTL and testbench



---
 rtl/mips32_pkg.sv | 73 +++++++
 rtl/mips32_alu.sv | 21 ++
 rtl/pipe_mips32.sv | 117 +++++++++++
 tb/tb_pipe_mips32.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Opcodes, instruction classes and pipeline-register layouts shared by the
// pipe_mips32 core and its ALU.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // NOP is encoded as zero so an all-zero pipeline register is a bubble.
    typedef enum logic [2:0] {
        NOP = 3'd0, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
    } itype_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        itype_t      kind;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        itype_t      kind;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        itype_t      kind;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] lmd;
    } mem_wb_t;

    function automatic itype_t decode(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    function automatic logic writes_reg(input itype_t k);
        return (k == RR_ALU) || (k == RM_ALU) || (k == LOAD);
    endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU; loads, stores and branch targets fall through to add.
module mips32_alu
    import mips32_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = a + b;
        case (op)
            OP_SUB, OP_SUBI: y = a - b;
            OP_AND:          y = a & b;
            OP_OR:           y = a | b;
            OP_SLT, OP_SLTI: y = {31'd0, $signed(a) < $signed(b)};
            OP_MUL:          y = a * b;
            default:         y = a + b;
        endcase
    end
endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core with EX forwarding, EX-resolved
// branches that squash two younger slots, and a HLT that drains the pipe.
module pipe_mips32
    import mips32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic halted
);
    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:1023];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    if_id_t  if_id;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    assign halted = HALTED;

    // write-back
    logic        wb_we;
    logic [31:0] wb_val;
    assign wb_we  = writes_reg(mem_wb.kind) && (mem_wb.dst != 5'd0);
    assign wb_val = (mem_wb.kind == LOAD) ? mem_wb.lmd : mem_wb.alu;

    // decode, with the register file bypassing a same-cycle write-back
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_a, id_b, id_imm;
    itype_t      id_kind;
    assign id_op   = if_id.ir[31:26];
    assign id_rs   = if_id.ir[25:21];
    assign id_rt   = if_id.ir[20:16];
    assign id_rd   = if_id.ir[15:11];
    assign id_imm  = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
    assign id_kind = if_id.vld ? decode(id_op) : NOP;

    always_comb begin
        id_a = Reg[id_rs];
        id_b = Reg[id_rt];
        if (id_rs == 5'd0) id_a = '0;
        else if (wb_we && mem_wb.dst == id_rs) id_a = wb_val;
        if (id_rt == 5'd0) id_b = '0;
        else if (wb_we && mem_wb.dst == id_rt) id_b = wb_val;
    end

    // execute operands: EX/MEM carries only ALU results, MEM/WB also loads
    logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_y;
    logic        mem_fwd_ok, taken, halt_pend;
    assign mem_fwd_ok = writes_reg(ex_mem.kind) && (ex_mem.kind != LOAD);

    always_comb begin
        fwd_a = id_ex.a;
        fwd_b = id_ex.b;
        if (id_ex.rs == 5'd0) fwd_a = '0;
        else if (mem_fwd_ok && ex_mem.dst == id_ex.rs) fwd_a = ex_mem.alu;
        else if (wb_we && mem_wb.dst == id_ex.rs) fwd_a = wb_val;
        if (id_ex.rt == 5'd0) fwd_b = '0;
        else if (mem_fwd_ok && ex_mem.dst == id_ex.rt) fwd_b = ex_mem.alu;
        else if (wb_we && mem_wb.dst == id_ex.rt) fwd_b = wb_val;
    end

    assign alu_a = (id_ex.kind == BRANCH) ? id_ex.npc : fwd_a;
    assign alu_b = (id_ex.kind == RR_ALU) ? fwd_b : id_ex.imm;

    mips32_alu u_alu (.op(id_ex.op), .a(alu_a), .b(alu_b), .y(alu_y));

    assign taken = (id_ex.kind == BRANCH) && ((id_ex.op == OP_BEQZ) == (fwd_a == '0));
    // fetch stays stopped from HLT decode until reset
    assign halt_pend = (id_kind == HALT) || (id_ex.kind == HALT) || (ex_mem.kind == HALT)
                     || (mem_wb.kind == HALT) || HALTED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id        <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= taken;
            if (mem_wb.kind == HALT) HALTED <= 1'b1;
            mem_wb <= '{kind: ex_mem.kind, dst: ex_mem.dst, alu: ex_mem.alu,
                        lmd: Mem[ex_mem.alu[9:0]]};
            ex_mem <= '{kind: id_ex.kind, dst: id_ex.dst, alu: alu_y, b: fwd_b};
            if (taken) begin
                PC    <= alu_y;
                if_id <= '0;
                id_ex <= '0;
            end else begin
                id_ex <= '{kind: id_kind, op: id_op, rs: id_rs, rt: id_rt,
                           dst: (id_kind == RR_ALU) ? id_rd : id_rt,
                           a: id_a, b: id_b, imm: id_imm, npc: if_id.npc};
                if (halt_pend) begin
                    if_id <= '0;
                end else begin
                    if_id <= '{vld: 1'b1, ir: Mem[PC[9:0]], npc: PC + 32'd1};
                    PC    <= PC + 32'd1;
                end
            end
        end
    end

    // architectural state is never reset; pipeline bubbles make writes inert
    always_ff @(posedge clk) begin
        if (!rst && !HALTED) begin
            if (wb_we) Reg[mem_wb.dst] <= wb_val;
            if (ex_mem.kind == STORE) Mem[ex_mem.alu[9:0]] <= ex_mem.b;
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed-program bench for pipe_mips32: each task loads a small program,
// runs it to HLT and checks registers, memory and flags against hand values.
module tb_pipe_mips32;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    int   total = 0;
    int   bad = 0;
    int   ntaken = 0;

    pipe_mips32 dut (.clk(clk), .rst(rst), .halted(halted));

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic setup();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        for (int a = 0; a < 1024; a++) dut.Mem[a] = '0;
    endtask

    task automatic load_prog1();
        dut.Mem[0]   = ri(OP_ADDI, 1, 0, 16'd120);
        dut.Mem[1]   = rr(OP_OR, 3, 3, 3);
        dut.Mem[2]   = ri(OP_LW, 2, 1, 16'd0);
        dut.Mem[3]   = rr(OP_OR, 3, 3, 3);
        dut.Mem[4]   = ri(OP_ADDI, 2, 2, 16'd45);
        dut.Mem[5]   = rr(OP_OR, 3, 3, 3);
        dut.Mem[6]   = ri(OP_SW, 2, 1, 16'd1);
        dut.Mem[7]   = {OP_HLT, 26'd0};
        dut.Mem[120] = 32'd85;
    endtask

    // releases reset and runs until halted or the clock budget runs out
    task automatic go(input int max_cyc, output int cyc);
        cyc = 0;
        ntaken = 0;
        @(negedge clk);
        rst = 1'b0;
        while (halted !== 1'b1 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (dut.TAKEN_BRANCH === 1'b1) ntaken++;
        end
    endtask

    task automatic test_reset();
        setup();
        total++; if (dut.PC !== 32'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", dut.PC); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (dut.TAKEN_BRANCH !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", dut.TAKEN_BRANCH); end
    endtask

    task automatic test_load_store();
        int cyc;
        setup();
        load_prog1();
        go(20, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ls_halt: halted=%b after %0d clocks want 1", halted, cyc); end
        total++; if (dut.Mem[121] !== 32'd130) begin bad++; $display("FAIL ls_mem121: got %0d want 130", dut.Mem[121]); end
        total++; if (dut.Reg[1] !== 32'd120) begin bad++; $display("FAIL ls_r1: got %0d want 120", dut.Reg[1]); end
        total++; if (dut.Reg[2] !== 32'd130) begin bad++; $display("FAIL ls_r2: got %0d want 130", dut.Reg[2]); end
        total++; if (dut.Mem[120] !== 32'd85) begin bad++; $display("FAIL ls_mem120: got %0d want 85", dut.Mem[120]); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [4:0]  idx [4] = '{5, 6, 7, 8};
        logic [31:0] exp [4] = '{32'd3, 32'd0, 32'd0, 32'd0};
        setup();
        dut.Mem[0] = rr(OP_ADD, 5, 1, 2);
        dut.Mem[1] = rr(OP_SUB, 6, 5, 3);
        dut.Mem[2] = rr(OP_MUL, 7, 6, 4);
        dut.Mem[3] = rr(OP_SLT, 8, 3, 7);
        dut.Mem[4] = {OP_HLT, 26'd0};
        go(20, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL b2b_halt: halted=%b want 1", halted); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dut.Reg[idx[i]] !== exp[i]) begin
                bad++; $display("FAIL b2b_r%0d: got %0d want %0d", idx[i], dut.Reg[idx[i]], exp[i]);
            end
        end
    endtask

    task automatic test_alu_ops();
        int cyc;
        logic [4:0]  idx [9] = '{13, 14, 15, 16, 17, 18, 19, 0, 20};
        logic [31:0] exp [9] = '{32'hFFFF_FFFB, 32'd1, 32'd4, 32'd15, 32'hFFFF_FFFD,
                                 32'd1, 32'hFFFF_FFF1, 32'd0, 32'd4};
        setup();
        dut.Mem[0] = ri(OP_ADDI, 13, 0, 16'hFFFB);
        dut.Mem[1] = rr(OP_SLT, 14, 13, 1);
        dut.Mem[2] = rr(OP_AND, 15, 7, 12);
        dut.Mem[3] = rr(OP_OR, 16, 9, 6);
        dut.Mem[4] = ri(OP_SUBI, 17, 2, 16'd5);
        dut.Mem[5] = ri(OP_SLTI, 18, 13, 16'd3);
        dut.Mem[6] = rr(OP_MUL, 19, 13, 3);
        dut.Mem[7] = rr(OP_ADD, 0, 5, 5);
        dut.Mem[8] = rr(OP_ADD, 20, 0, 4);
        dut.Mem[9] = {OP_HLT, 26'd0};
        go(30, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL alu_halt: halted=%b want 1", halted); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (dut.Reg[idx[i]] !== exp[i]) begin
                bad++; $display("FAIL alu_r%0d: got %h want %h", idx[i], dut.Reg[idx[i]], exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        int cyc;
        setup();
        dut.Mem[0] = ri(OP_BEQZ, 0, 0, 16'd2);
        dut.Mem[1] = ri(OP_ADDI, 9, 0, 16'd1);
        dut.Mem[2] = ri(OP_ADDI, 10, 0, 16'd1);
        dut.Mem[3] = ri(OP_ADDI, 11, 0, 16'd1);
        dut.Mem[4] = {OP_HLT, 26'd0};
        go(30, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL beqz_halt: halted=%b want 1", halted); end
        total++; if (dut.Reg[9] !== 32'd9) begin bad++; $display("FAIL beqz_r9: got %0d want 9", dut.Reg[9]); end
        total++; if (dut.Reg[10] !== 32'd10) begin bad++; $display("FAIL beqz_r10: got %0d want 10", dut.Reg[10]); end
        total++; if (dut.Reg[11] !== 32'd1) begin bad++; $display("FAIL beqz_r11: got %0d want 1", dut.Reg[11]); end
        total++; if (ntaken !== 1) begin bad++; $display("FAIL beqz_taken_cycles: got %0d want 1", ntaken); end

        setup();
        dut.Mem[0] = ri(OP_BNEQZ, 0, 0, 16'd2);
        dut.Mem[1] = ri(OP_ADDI, 9, 0, 16'd1);
        dut.Mem[2] = ri(OP_ADDI, 10, 0, 16'd1);
        dut.Mem[3] = {OP_HLT, 26'd0};
        go(30, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL bneqz_halt: halted=%b want 1", halted); end
        total++; if (dut.Reg[9] !== 32'd1) begin bad++; $display("FAIL bneqz_r9: got %0d want 1", dut.Reg[9]); end
        total++; if (dut.Reg[10] !== 32'd1) begin bad++; $display("FAIL bneqz_r10: got %0d want 1", dut.Reg[10]); end
        total++; if (ntaken !== 0) begin bad++; $display("FAIL bneqz_taken_cycles: got %0d want 0", ntaken); end
    endtask

    // loop branch is directly followed by HLT, which each taken pass squashes
    task automatic test_factorial();
        int cyc;
        setup();
        dut.Mem[200] = 32'd7;
        dut.Mem[0] = ri(OP_ADDI, 10, 0, 16'd200);
        dut.Mem[1] = ri(OP_ADDI, 2, 0, 16'd1);
        dut.Mem[2] = ri(OP_LW, 3, 10, 16'd0);
        dut.Mem[3] = rr(OP_OR, 20, 20, 20);
        dut.Mem[4] = rr(OP_MUL, 2, 2, 3);
        dut.Mem[5] = ri(OP_SUBI, 3, 3, 16'd1);
        dut.Mem[6] = ri(OP_SW, 2, 10, 16'hFFFE);
        dut.Mem[7] = ri(OP_BNEQZ, 0, 3, 16'hFFFC);
        dut.Mem[8] = {OP_HLT, 26'd0};
        go(200, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL fact_halt: halted=%b want 1", halted); end
        total++; if (dut.Mem[198] !== 32'd5040) begin bad++; $display("FAIL fact_mem198: got %0d want 5040", dut.Mem[198]); end
        total++; if (dut.Reg[2] !== 32'd5040) begin bad++; $display("FAIL fact_r2: got %0d want 5040", dut.Reg[2]); end
        total++; if (dut.Reg[3] !== 32'd0) begin bad++; $display("FAIL fact_r3: got %0d want 0", dut.Reg[3]); end
        total++; if (ntaken !== 6) begin bad++; $display("FAIL fact_taken_cycles: got %0d want 6", ntaken); end
    endtask

    task automatic test_halt_freeze();
        int cyc;
        int drop = 0;
        setup();
        dut.Mem[300] = 32'h55;
        dut.Mem[0] = {OP_HLT, 26'd0};
        dut.Mem[1] = ri(OP_ADDI, 12, 0, 16'd99);
        dut.Mem[2] = ri(OP_SW, 12, 0, 16'd300);
        go(20, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL hlt_halt: halted=%b want 1", halted); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted !== 1'b1) drop++;
        end
        total++; if (drop !== 0) begin bad++; $display("FAIL hlt_sticky: halted low on %0d clocks want 0", drop); end
        total++; if (dut.Reg[12] !== 32'd12) begin bad++; $display("FAIL hlt_r12: got %0d want 12", dut.Reg[12]); end
        total++; if (dut.Mem[300] !== 32'h55) begin bad++; $display("FAIL hlt_mem300: got %h want 55", dut.Mem[300]); end
        total++; if (dut.PC !== 32'd1) begin bad++; $display("FAIL hlt_pc: got %0d want 1", dut.PC); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        setup();
        load_prog1();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (dut.PC !== 32'd0) begin bad++; $display("FAIL mid_pc: got %0d want 0", dut.PC); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_halted: got %b want 0", halted); end
        total++; if (dut.Mem[120] !== 32'd85) begin bad++; $display("FAIL mid_mem120: got %0d want 85", dut.Mem[120]); end
        total++; if (dut.Mem[7] !== {OP_HLT, 26'd0}) begin bad++; $display("FAIL mid_mem7: got %h want fc000000", dut.Mem[7]); end
        go(20, cyc);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL mid_rerun_halt: halted=%b want 1", halted); end
        total++; if (dut.Mem[121] !== 32'd130) begin bad++; $display("FAIL mid_mem121: got %0d want 130", dut.Mem[121]); end
        total++; if (dut.Reg[2] !== 32'd130) begin bad++; $display("FAIL mid_r2: got %0d want 130", dut.Reg[2]); end
        #2 rst = 1'b1;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL post_halt_reset: got %b want 0", halted); end
        total++; if (dut.Mem[121] !== 32'd130) begin bad++; $display("FAIL post_halt_mem121: got %0d want 130", dut.Mem[121]); end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_back_to_back();
        test_alu_ops();
        test_branch();
        test_factorial();
        test_halt_freeze();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
